// File: rtl/soc_pkg.sv
// Shared SoC definitions: timer slave address window, register offsets and CTRL bit layout.
package soc_pkg;

    localparam logic [31:0] TIMER_BASE = 32'h0004_0000;
    localparam logic [31:0] TIMER_MASK = 32'h0000_000f;

    typedef enum logic [1:0] {
        TMR_CTRL  = 2'd0,
        TMR_PRESC = 2'd1,
        TMR_COUNT = 2'd2,
        TMR_CMP   = 2'd3
    } tmr_reg_e;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_IRQ  = 2;
    localparam int CTRL_FLAG = 8;

    // Replace only the bytes of old_v selected by be with the matching bytes of new_v.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant SoC bus with separate read and write channels.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    input  rd_gnt, rd_data, wr_gnt);
    modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/timer_prescaler.sv
// Prescale counter: counts 0..limit_i while enabled and emits a one-cycle tick on the wrap.
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PRESCALE_W-1:0] limit_i,
    output logic                  tick_o
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // A clear (disable or new limit) restarts the period and suppresses the tick.
    assign tick_o = en_i && !clr_i && (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer/compare slave: prescaled counter, compare flag with auto-reload, level irq.
module bus_timer
    import soc_pkg::*;
#(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hffff_ffff
) (
    input  logic     clk,
    input  logic     rst_n,
    naive_bus.slave  bus,
    output logic     o_irq
);

    logic                  en_q, en_d;
    logic                  ar_q, ar_d;
    logic                  irq_en_q, irq_en_d;
    logic                  flag_q, flag_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           cmp_q, cmp_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic                  irq_q, irq_d;

    tmr_reg_e wr_sel, rd_sel;
    logic     wr_ctrl, wr_presc, wr_count, wr_cmp;
    logic     w1c, tick, match;
    logic     unused_addr_bits;

    assign bus.rd_gnt = bus.rd_req;
    assign bus.wr_gnt = bus.wr_req;
    assign bus.rd_data = rd_data_q;
    assign o_irq = irq_q;

    assign unused_addr_bits = ^{bus.rd_addr[31:4], bus.rd_addr[1:0],
                                bus.wr_addr[31:4], bus.wr_addr[1:0]};

    assign wr_sel   = tmr_reg_e'(bus.wr_addr[3:2]);
    assign rd_sel   = tmr_reg_e'(bus.rd_addr[3:2]);
    assign wr_ctrl  = bus.wr_req && (wr_sel == TMR_CTRL);
    assign wr_presc = bus.wr_req && (wr_sel == TMR_PRESC);
    assign wr_count = bus.wr_req && (wr_sel == TMR_COUNT);
    assign wr_cmp   = bus.wr_req && (wr_sel == TMR_CMP);
    assign w1c      = wr_ctrl && bus.wr_be[1] && bus.wr_data[CTRL_FLAG];

    timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en_q),
        .clr_i   (wr_presc),
        .limit_i (presc_q),
        .tick_o  (tick)
    );

    // Compare always sees the registered COUNT/COMPARE, never this cycle's bus write.
    assign match = tick && (count_q == cmp_q);

    always_comb begin
        en_d     = en_q;
        ar_d     = ar_q;
        irq_en_d = irq_en_q;
        presc_d  = presc_q;
        count_d  = count_q;
        cmp_d    = cmp_q;

        if (wr_ctrl && bus.wr_be[0]) begin
            en_d     = bus.wr_data[CTRL_EN];
            ar_d     = bus.wr_data[CTRL_AR];
            irq_en_d = bus.wr_data[CTRL_IRQ];
        end
        if (wr_presc) begin
            presc_d = PRESCALE_W'(byte_merge(32'(presc_q), bus.wr_data, bus.wr_be));
        end
        if (wr_cmp) begin
            cmp_d = byte_merge(cmp_q, bus.wr_data, bus.wr_be);
        end

        if (tick) begin
            count_d = (match && ar_q) ? 32'd0 : count_q + 32'd1;
        end
        if (wr_count) begin
            count_d = byte_merge(count_q, bus.wr_data, bus.wr_be);
        end

        flag_d = match || (flag_q && !w1c);
        irq_d  = flag_d && irq_en_d;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rd_req) begin
            unique case (rd_sel)
                TMR_CTRL:  rd_data_d = {23'd0, flag_q, 5'd0, irq_en_q, ar_q, en_q};
                TMR_PRESC: rd_data_d = 32'(presc_q);
                TMR_COUNT: rd_data_d = count_q;
                TMR_CMP:   rd_data_d = cmp_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            flag_q    <= 1'b0;
            presc_q   <= '0;
            count_q   <= 32'd0;
            cmp_q     <= RESET_COMPARE;
            rd_data_q <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            ar_q      <= ar_d;
            irq_en_q  <= irq_en_d;
            flag_q    <= flag_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            cmp_q     <= cmp_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register vector table plus timing sequences for ticks, flags and reset.
module tb_bus_timer;
    import soc_pkg::*;

    localparam logic [31:0] A_CTRL  = TIMER_BASE | 32'h0;
    localparam logic [31:0] A_PRESC = TIMER_BASE | 32'h4;
    localparam logic [31:0] A_COUNT = TIMER_BASE | 32'h8;
    localparam logic [31:0] A_CMP   = TIMER_BASE | 32'hc;

    logic clk;
    logic rst_n;
    logic o_irq;
    int   n_tests;
    int   n_fail;

    naive_bus bus_if();

    bus_timer #(.PRESCALE_W(16), .RESET_COMPARE(32'hffff_ffff)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .o_irq (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act,
                               input logic [31:0] lo, input logic [31:0] hi);
        n_tests++;
        if ((act < lo) || (act > hi)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.rd_req  = 1'b0;
        bus_if.rd_addr = 32'd0;
        bus_if.wr_req  = 1'b0;
        bus_if.wr_addr = 32'd0;
        bus_if.wr_data = 32'd0;
        bus_if.wr_be   = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge; the write commits on the following posedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_if.wr_req  = 1'b1;
        bus_if.wr_addr = addr;
        bus_if.wr_data = data;
        bus_if.wr_be   = be;
        #1 check("wr_gnt", 32'(bus_if.wr_gnt), 32'd1);
        @(negedge clk);
        bus_if.wr_req = 1'b0;
        bus_if.wr_be  = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = addr;
        #1 check("rd_gnt", 32'(bus_if.rd_gnt), 32'd1);
        @(negedge clk);
        data = bus_if.rd_data;
        bus_if.rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] wrap_exp [4];

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{A_CMP,            32'haabb_ccdd, 4'b0101, 32'hffbb_ffdd};
        vecs[1]  = '{TIMER_BASE | 32'he, 32'h1234_5678, 4'b1111, 32'h1234_5678};
        vecs[2]  = '{A_PRESC,          32'hffff_1234, 4'b1111, 32'h0000_1234};
        vecs[3]  = '{A_PRESC,          32'h0000_ab00, 4'b0010, 32'h0000_ab34};
        vecs[4]  = '{A_COUNT,          32'h0000_0005, 4'b1111, 32'h0000_0005};
        vecs[5]  = '{A_COUNT,          32'haaaa_aaaa, 4'b1000, 32'haa00_0005};
        vecs[6]  = '{A_CTRL,           32'hffff_fef6, 4'b0001, 32'h0000_0006};
        vecs[7]  = '{A_CTRL,           32'h0000_0100, 4'b0010, 32'h0000_0006};
        vecs[8]  = '{A_CTRL,           32'h0000_0000, 4'b0000, 32'h0000_0006};
        vecs[9]  = '{A_CTRL,           32'h0000_0000, 4'b1111, 32'h0000_0000};
        vecs[10] = '{A_COUNT,          32'hffff_ffff, 4'b0000, 32'haa00_0005};

        // Reset state
        do_reset();
        check("rst_rd_data", bus_if.rd_data, 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_rd_gnt_idle", 32'(bus_if.rd_gnt), 32'd0);
        check("rst_wr_gnt_idle", 32'(bus_if.wr_gnt), 32'd0);
        bus_read(A_CTRL, rd);  check("rst_ctrl", rd, 32'd0);
        bus_read(A_PRESC, rd); check("rst_presc", rd, 32'd0);
        bus_read(A_COUNT, rd); check("rst_count", rd, 32'd0);
        bus_read(A_CMP, rd);   check("rst_cmp", rd, 32'hffff_ffff);

        // Register write/readback with the timer stopped
        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Prescale by 4
        do_reset();
        bus_write(A_PRESC, 32'd3, 4'hf);
        bus_write(A_CTRL, 32'd1, 4'hf);
        repeat (40) @(negedge clk);
        bus_write(A_CTRL, 32'd0, 4'hf);
        bus_read(A_COUNT, rd);
        check_range("presc_count", rd, 32'd9, 32'd11);
        repeat (5) @(negedge clk);
        bus_read(A_COUNT, rd);
        check_range("presc_hold", rd, 32'd9, 32'd11);

        // Auto-reload match with irq
        do_reset();
        bus_write(A_CMP, 32'd4, 4'hf);
        bus_write(A_CTRL, 32'd7, 4'hf);
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = A_COUNT;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("ar_count%0d", i), bus_if.rd_data, 32'(i % 5));
            check($sformatf("ar_irq%0d", i), 32'(o_irq), (i >= 4) ? 32'd1 : 32'd0);
        end
        bus_if.rd_req = 1'b0;
        bus_read(A_CTRL, rd);               check("ar_ctrl", rd, 32'h107);
        bus_write(A_CTRL, 32'h100, 4'b0010); check("w1c_irq_low", 32'(o_irq), 32'd0);
        bus_read(A_CTRL, rd);               check("w1c_ctrl", rd, 32'h007);
        check("rematch_irq", 32'(o_irq), 32'd1);
        bus_read(A_CTRL, rd);               check("rematch_ctrl", rd, 32'h107);
        repeat (3) @(negedge clk);
        bus_write(A_CTRL, 32'h100, 4'b0010);
        bus_read(A_CTRL, rd);               check("w1c_vs_match", rd, 32'h107);
        bus_write(A_CTRL, 32'h107, 4'b0001);
        bus_read(A_CTRL, rd);               check("w1c_needs_be1", rd, 32'h107);
        bus_write(A_CTRL, 32'h003, 4'b0001); check("irq_en_off", 32'(o_irq), 32'd0);

        // 32-bit wrap without reload
        do_reset();
        wrap_exp[0] = 32'hffff_fffe;
        wrap_exp[1] = 32'hffff_ffff;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;
        bus_write(A_COUNT, 32'hffff_fffe, 4'hf);
        bus_write(A_CTRL, 32'd1, 4'hf);
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = A_COUNT;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("wrap%0d", i), bus_if.rd_data, wrap_exp[i]);
            check($sformatf("wrap_irq%0d", i), 32'(o_irq), 32'd0);
        end
        bus_if.rd_req = 1'b0;
        bus_read(A_CTRL, rd);               check("wrap_ctrl", rd, 32'h101);
        bus_write(A_COUNT, 32'h100, 4'hf);
        bus_read(A_COUNT, rd);              check("count_wr_vs_tick", rd, 32'h100);

        // Reset in the middle of operation
        do_reset();
        bus_write(A_COUNT, 32'd5, 4'hf);
        bus_write(A_CMP, 32'd5, 4'hf);
        bus_write(A_CTRL, 32'd5, 4'hf);
        @(negedge clk);
        check("pre_rst_irq", 32'(o_irq), 32'd1);
        bus_read(A_COUNT, rd);              check("pre_rst_count", rd, 32'd6);
        bus_if.rd_req  = 1'b1;
        bus_if.rd_addr = A_CTRL;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_irq", 32'(o_irq), 32'd0);
        check("async_rst_rd_data", bus_if.rd_data, 32'd0);
        @(negedge clk);
        bus_if.rd_req = 1'b0;
        rst_n = 1'b1;
        bus_read(A_CTRL, rd);               check("post_rst_ctrl", rd, 32'd0);
        bus_read(A_COUNT, rd);              check("post_rst_count", rd, 32'd0);
        check("post_rst_irq", 32'(o_irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral; sixth slave on the SoC naive_bus router at 00040000~0004000f (SLAVES_MASK 32'h0000_000f).
- Provides a prescaled free-running counter, a compare match flag with optional auto-reload, and a level interrupt output for the core.
- Always-grant slave: zero wait states, fixed one-cycle read latency, like the other SoC RAM slaves.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescale counter (1..32).
- RESET_COMPARE, 32'hffff_ffff, reset value of the COMPARE register.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- bus  naive_bus.slave  -  rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0], wr_req, wr_gnt, wr_addr[31:0], wr_data[31:0], wr_be[3:0]
- o_irq  output  1  level interrupt, high while FLAG=1 and IRQ_EN=1

Behaviour:
- Register map, decoded on addr[3:2]; addr[1:0] ignored:
  - 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bit8 FLAG (read; write 1 clears), others read 0.
  - 0x4 PRESCALE[PRESCALE_W-1:0].
  - 0x8 COUNT.
  - 0xc COMPARE.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=RESET_COMPARE, prescale counter=0, rd_data=0, o_irq=0.
- Bus handshake:
  - rd_gnt=rd_req and wr_gnt=wr_req, combinational.
  - Read: rd_data is registered and valid the cycle after rd_req&rd_gnt. It holds its last value when there is no read.
  - Write: takes effect at the clock edge of wr_req&wr_gnt. wr_be[i] gates byte i.
  - PRESCALE bits above PRESCALE_W are dropped. FLAG clears only when wr_be[1]=1 and wr_data[8]=1.
  - Simultaneous read and write of the same register: the read returns the pre-write value.
- Tick generation:
  - With EN=1, the prescale counter increments each cycle. On reaching PRESCALE it wraps to 0 and asserts a one-cycle tick.
  - PRESCALE=0 therefore gives a tick every cycle.
  - EN=0 or any write to PRESCALE forces the prescale counter to 0. No tick is issued in that cycle.
- Counting on tick:
  - If COUNT==COMPARE: FLAG<=1, and COUNT<=0 when AUTO_RELOAD=1, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping modulo 2^32 (ffffffff->0).
  - With EN=0, COUNT holds.
- Precedence, highest first:
  - A bus write to COUNT overrides tick increment and reload in the same cycle. The compare test still uses the pre-write COUNT.
  - FLAG set by a match beats a W1C clear in the same cycle (FLAG stays 1).
  - A write to COMPARE is used from the next cycle.
- o_irq is registered: o_irq <= FLAG_next & IRQ_EN_next. It is asserted the cycle after the tick that sets FLAG, and deasserted the cycle after the clear or IRQ_EN=0.
- Mid-operation reset: all state returns to reset values asynchronously and o_irq drops immediately. A read in flight returns 0.

Decomposition:
- Package soc_pkg: TIMER_BASE=32'h0004_0000, TIMER_MASK=32'h0000_000f, register offsets (TMR_CTRL=2'd0, TMR_PRESC=2'd1, TMR_COUNT=2'd2, TMR_CMP=2'd3), CTRL bit indices.
- One sub-module, timer_prescaler: enable, load-clear and limit inputs, tick output. The bus decode and registers stay in bus_timer.
- soc_top changes: N_SLAVE=6, bus_slaves[6], router BASE/MASK extended, o_irq wired to the core.

Test Plan:
- Reset mid-count: assert rst_n=0 while COUNT=5 -> COUNT=0, o_irq=0 immediately, and a CTRL read then returns 0.
- Prescale: PRESCALE=3, CTRL=1 -> COUNT increments once every 4 clk; after 40 cycles COUNT=10 (±1 for the enable edge).
- Auto-reload match: COMPARE=4, PRESCALE=0, CTRL=0x7 -> sequence 0,1,2,3,4,0,1…; FLAG=1 on the 4->0 tick; o_irq high the next cycle; CTRL reads 0x107.
- Wrap and no reload: COUNT=ffff_fffe, COMPARE=ffff_ffff, CTRL=1 -> fffffffe,ffffffff,0,1; FLAG set on the ffffffff->0 tick; o_irq stays 0 because IRQ_EN=0.
- Collisions:
  - Write COUNT=0x100 on a tick cycle -> next read gives 0x100.
  - W1C of FLAG in the same cycle as a new match -> FLAG remains 1.
- Byte enables: write 0xAABBCCDD to COMPARE with wr_be=4'b0101 over ffffffff -> read gives ffbbffdd with one-cycle latency and rd_gnt=rd_req.
